// File: rtl/fractional_vec_addsub.sv
// Two-stage, multi-lane unsigned fractional (UQ0.N) add/subtract unit with
// wrap/saturate modes, per-lane carry/borrow flags, valid/ready flow control
// and a saturating overflow-event counter for debug.
module fractional_vec_addsub #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_a,
    input  logic [LANES*DATA_WIDTH-1:0] in_b,
    input  logic                        in_op,
    input  logic                        in_sat,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_ovf,
    input  logic                        cnt_clr,
    output logic [CNT_WIDTH-1:0]        ovf_count
);

    localparam int unsigned VecWidth = LANES * DATA_WIDTH;

    // Stage 1 operand registers
    logic                s1_valid;
    logic [VecWidth-1:0] s1_a;
    logic [VecWidth-1:0] s1_b;
    logic                s1_op;
    logic                s1_sat;

    // Stage 2 result registers
    logic                s2_valid;
    logic [VecWidth-1:0] s2_data;
    logic [LANES-1:0]    s2_ovf;

    logic                s1_adv;
    logic                s2_adv;

    // Lane results computed from stage 1 contents
    logic [VecWidth-1:0]   lane_res;
    logic [LANES-1:0]      lane_ovf;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] lane_a;
    logic [DATA_WIDTH-1:0] lane_b;

    // Backpressure propagates combinationally from the consumer to the producer
    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = !s1_valid || s2_adv;
        in_ready = s1_adv;
    end

    // Per-lane add/sub; the extra MSB of the intermediate is the carry or borrow
    always_comb begin
        lane_res = '0;
        lane_ovf = '0;
        sum      = '0;
        diff     = '0;
        lane_a   = '0;
        lane_b   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lane_a = s1_a[i*DATA_WIDTH +: DATA_WIDTH];
            lane_b = s1_b[i*DATA_WIDTH +: DATA_WIDTH];
            sum    = {1'b0, lane_a} + {1'b0, lane_b};
            diff   = {1'b0, lane_a} - {1'b0, lane_b};
            if (!s1_op) begin
                lane_ovf[i] = sum[DATA_WIDTH];
                if (s1_sat && sum[DATA_WIDTH]) begin
                    lane_res[i*DATA_WIDTH +: DATA_WIDTH] = '1;
                end else begin
                    lane_res[i*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
                end
            end else begin
                // Borrow out of the widened subtraction is exactly (a < b)
                lane_ovf[i] = diff[DATA_WIDTH];
                if (s1_sat && diff[DATA_WIDTH]) begin
                    lane_res[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                end else begin
                    lane_res[i*DATA_WIDTH +: DATA_WIDTH] = diff[DATA_WIDTH-1:0];
                end
            end
        end
    end

    // Stage 1: capture the operand bundle whenever the stage can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= 1'b0;
            s1_sat   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid && in_ready;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
            s1_sat   <= in_sat;
        end
    end

    // Stage 2: register results; data is only replaced by a valid bundle so the
    // outputs keep their last value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= lane_res;
                s2_ovf  <= lane_ovf;
            end
        end
    end

    // Overflow-event counter: clear wins, otherwise saturating increment per
    // output transfer carrying any flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (cnt_clr) begin
            ovf_count <= '0;
        end else if (s2_valid && out_ready && (|s2_ovf) && (ovf_count != '1)) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_ovf   = s2_ovf;

endmodule

// File: tb/tb_fractional_vec_addsub.sv
// Directed self-checking bench for fractional_vec_addsub. A second instance with
// a 2-bit counter shares all inputs to exercise counter saturation.
module tb_fractional_vec_addsub;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_op;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_ovf;
    logic        cnt_clr;
    logic [15:0] ovf_count;

    logic        in_ready_s;
    logic        out_valid_s;
    logic [31:0] out_data_s;
    logic [3:0]  out_ovf_s;
    logic [1:0]  ovf_count_s;

    int vectors;
    int miscompares;

    fractional_vec_addsub #(
        .DATA_WIDTH(8),
        .LANES     (4),
        .CNT_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .in_sat   (in_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .cnt_clr  (cnt_clr),
        .ovf_count(ovf_count)
    );

    fractional_vec_addsub #(
        .DATA_WIDTH(8),
        .LANES     (4),
        .CNT_WIDTH (2)
    ) dut_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready_s),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_op    (in_op),
        .in_sat   (in_sat),
        .out_valid(out_valid_s),
        .out_ready(out_ready),
        .out_data (out_data_s),
        .out_ovf  (out_ovf_s),
        .cnt_clr  (cnt_clr),
        .ovf_count(ovf_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single bundle on an empty pipeline; checks 2-cycle latency and the result
    task automatic one(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic sat,
                       input logic [31:0] exp_data, input logic [3:0] exp_ovf);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_sat    = sat;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, out_valid, 0);
        step();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_ovf"}, out_ovf, exp_ovf);
    endtask

    logic [31:0] expq[$];
    logic [31:0] held;
    logic        stall_prev;
    int          out_cnt;
    int          last_out;
    int          k;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_op       = 1'b0;
        in_sat      = 1'b0;
        out_ready   = 1'b1;
        cnt_clr     = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_count", ovf_count, 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // No-carry add
        one("add_nc", 32'h0000_0040, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0060, 4'b0000);
        step();
        chk("add_nc_count", ovf_count, 0);

        // Four lanes, wrap then saturate
        one("add_wrap", 32'hFFC0_20A0, 32'h0180_6020, 1'b0, 1'b0, 32'h0040_80C0, 4'b1100);
        one("add_sat", 32'hFFC0_20A0, 32'h0180_6020, 1'b0, 1'b1, 32'hFFFF_80C0, 4'b1100);
        step();
        chk("add_count", ovf_count, 2);
        chk("add_count_small", ovf_count_s, 2);

        // Subtraction
        one("sub_nb", 32'h0000_0060, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0040, 4'b0000);
        one("sub_wrap", 32'h0000_0020, 32'h0000_0060, 1'b1, 1'b0, 32'h0000_00C0, 4'b0001);
        one("sub_sat", 32'h0000_0020, 32'h0000_0060, 1'b1, 1'b1, 32'h0000_0000, 4'b0001);
        step();
        chk("sub_count", ovf_count, 4);
        chk("sub_count_small_sat", ovf_count_s, 3);

        // Backpressure: six back-to-back bundles, consumer stalls cycles 3..6
        out_cnt    = 0;
        last_out   = -1;
        k          = 0;
        stall_prev = 1'b0;
        held       = '0;
        for (int c = 0; c < 15; c++) begin
            in_valid  = (k < 6);
            in_a      = 32'h1020_3040 + k;
            in_b      = 32'h0101_0101;
            in_op     = 1'b0;
            in_sat    = 1'b0;
            out_ready = !(c >= 3 && c <= 6);
            #1;
            chk("bp_in_ready", in_ready, !(c >= 3 && c <= 6));
            if (stall_prev) begin
                chk("bp_hold_valid", out_valid, 1);
                chk("bp_hold_data", out_data, held);
            end
            if (in_valid && in_ready) begin
                expq.push_back(32'h1121_3141 + k);
                k++;
            end
            if (out_valid && out_ready) begin
                chk("bp_queue_nonempty", expq.size() > 0, 1);
                if (expq.size() > 0) chk("bp_order", out_data, expq.pop_front());
                out_cnt++;
                last_out = c;
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", k, 6);
        chk("bp_out_count", out_cnt, 6);
        chk("bp_last_out_cycle", last_out, 11);
        chk("bp_drained_valid", out_valid, 0);

        // Counter: clear, then five overflowing bundles, then clear vs increment
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_count", ovf_count, 0);
        chk("clr_count_small", ovf_count_s, 0);
        in_a      = 32'h0000_00FF;
        in_b      = 32'h0000_0001;
        in_op     = 1'b0;
        in_sat    = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("cnt5_count", ovf_count, 5);
        chk("cnt5_count_small_sat", ovf_count_s, 3);
        one("cnt_ovf", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0001);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_prio_count", ovf_count, 0);
        chk("clr_prio_count_small", ovf_count_s, 0);

        // Reset with two bundles in flight
        one("pre_rst", 32'h0000_00FF, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0001, 4'b0001);
        step();
        chk("pre_rst_count", ovf_count, 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 32'h1111_1111;
        in_b      = 32'h2222_2222;
        step();
        in_a = 32'h3333_3333;
        step();
        in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        chk("inflight_data", out_data, 32'h3333_3333);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_ovf", out_ovf, 0);
        chk("async_rst_count", ovf_count, 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_no_stale", out_valid, 0);
        step();
        chk("post_rst_no_stale2", out_valid, 0);
        one("post_rst", 32'h0102_0304, 32'h1010_1010, 1'b0, 1'b1, 32'h1112_1314, 4'b0000);
        step();
        chk("post_rst_drained", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fractional_vec_addsub.md
Name: fractional_vec_addsub

Overview:
Pipelined, multi-lane unsigned fractional (UQ0.N) add/subtract unit. It is the next generation of the single-lane combinational fractional adder, adding LANES parallel lanes, subtraction, a selectable wrap or saturate mode, per-lane overflow flags and a valid/ready handshake. It sits in the Execution stage between the operand-fetch buffer and the writeback stage. A saturating overflow-event counter is provided for debug.

Parameters:
DATA_WIDTH, 8, bits per lane; lane value = x / 2^DATA_WIDTH (UQ0.DATA_WIDTH).
LANES, 4, number of parallel lanes (>=1).
CNT_WIDTH, 16, width of the overflow-event counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand bundle valid.
in_ready  out  1  unit can accept a bundle this cycle.
in_a  in  LANES*DATA_WIDTH  operand A; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
in_b  in  LANES*DATA_WIDTH  operand B; same packing as in_a.
in_op  in  1  0 = A+B, 1 = A-B; applies to all lanes of the bundle.
in_sat  in  1  0 = wrap, 1 = saturate; applies to all lanes of the bundle.
out_valid  out  1  result bundle valid.
out_ready  in  1  consumer accepts the result.
out_data  out  LANES*DATA_WIDTH  results, packed the same way as in_a.
out_ovf  out  LANES  per-lane carry (add) or borrow (sub) flag.
cnt_clr  in  1  synchronous clear of ovf_count.
ovf_count  out  CNT_WIDTH  number of output transfers in which any out_ovf bit was set.

Behaviour:
- Reset (rst_n = 0, asynchronous): both stage-valid bits, out_valid, out_data, out_ovf and ovf_count go to 0. in_ready is 1 one cycle after reset release. Any bundle in flight when reset asserts is discarded, with no partial output.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Pipeline:
  - S1 registers a, b, op and sat.
  - S2 computes each lane and registers out_data/out_ovf; out_valid is the S2 valid bit.
  - Latency is 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 bundle per cycle.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no registered skid).
  - On s2_adv, S2 loads S1's contents, and s2_valid takes s1_valid.
  - On s1_adv, S1 loads the input bundle, and s1_valid takes in_valid & in_ready.
- Stall: while out_valid & !out_ready, out_data/out_ovf/out_valid hold stable. At most 2 bundles are held. No bundle is ever dropped or duplicated.
- Lane arithmetic, using a DATA_WIDTH+1-bit intermediate:
  - Add: s = a + b; ovf = s[DATA_WIDTH]. Wrap gives s[DATA_WIDTH-1:0]. Saturate gives all ones if ovf, else s[DATA_WIDTH-1:0].
  - Sub: d = a - b; ovf = (a < b). Wrap gives d[DATA_WIDTH-1:0] (mod 2^DATA_WIDTH). Saturate gives 0 if ovf, else d[DATA_WIDTH-1:0].
  - out_ovf reports carry/borrow in both modes. Lanes are independent, with no inter-lane carry.
- Counter:
  - On an output transfer with |out_ovf, ovf_count increments by 1.
  - It saturates at 2^CNT_WIDTH-1 and never wraps.
  - cnt_clr forces 0 and has priority over a simultaneous increment.
  - Bundles without overflow do not change the count.
- Outputs when out_valid = 0 are don't-care for the consumer, but the implementation holds the last value (no X).

Test Plan:
- No-carry add (lane0): A=0x40, B=0x20, op=0, sat=0, out_ready=1 -> 2 cycles later out_valid=1, lane0 = 0x60, ovf[0]=0; ovf_count stays 0.
- Carry within range and overflow, wrap vs saturate, one 4-lane bundle: lanes {0xA0+0x20, 0x20+0x60, 0xC0+0x80, 0xFF+0x01} with sat=0 -> {0xC0, 0x80, 0x40, 0x00}, ovf=4'b1100. Same bundle with sat=1 -> {0xC0, 0x80, 0xFF, 0xFF}. ovf_count = 2 after both bundles.
- Subtraction: A=0x60, B=0x20 -> 0x40, ovf=0. A=0x20, B=0x60 -> wrap 0xC0 / sat 0x00, ovf=1.
- Backpressure: stream 6 bundles back-to-back with out_ready low for cycles 3-6:
  - in_ready drops after 2 bundles are held.
  - out_data stays stable while stalled.
  - All 6 results emerge in order with no loss or duplication.
  - Full throughput resumes once out_ready returns high.
- Counter: with CNT_WIDTH=2, issue 5 overflowing bundles -> ovf_count saturates at 3. Then cnt_clr pulsed in the same cycle as an overflowing output transfer -> ovf_count = 0.
- Reset mid-operation: assert rst_n=0 with 2 bundles in flight -> out_valid, out_data and ovf_count go to 0 immediately (asynchronously). After release, the first new bundle appears 2 cycles after its acceptance and no stale result appears.
